// File: rtl/hilo_muldiv_ctrl_if.sv
// rtl/hilo_muldiv_ctrl_if.sv - issue/read bus between EX decode and the HI/LO mul/div unit
interface hilo_muldiv_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rd_hilo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  modport master (
    output start, op, rs_val, rt_val, rd_hilo,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, rs_val, rt_val, rd_hilo,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - HI/LO registers with iterative multiply/divide and EX stall
module hilo_muldiv_ctrl #(
  parameter int ITER = 32
) (
  input  logic               clk,
  input  logic               reset,
  hilo_muldiv_ctrl_if.slave  bus
);
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          is_div;
  logic          is_signed;
  logic [31:0]   opa;
  logic [31:0]   opb;
  logic          qsign;
  logic          rsign;
  logic [31:0]   acc_hi;
  logic [31:0]   acc_lo;
  logic [31:0]   hi_r;
  logic [31:0]   lo_r;
  logic          done_r;

  logic          zero_div;
  logic          use_sign;
  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic [32:0]   mul_sum;
  logic [32:0]   div_shift;
  logic [32:0]   div_diff;
  logic [63:0]   prod_mag;
  logic [63:0]   prod_fix;
  logic [31:0]   quo_fix;
  logic [31:0]   rem_fix;

  // Divide by zero skips the signed path so hi returns the raw dividend.
  always_comb begin
    zero_div  = is_div && (opb == 32'd0);
    use_sign  = is_signed && !zero_div;
    mag_a     = (use_sign && opa[31]) ? -opa : opa;
    mag_b     = (use_sign && opb[31]) ? -opb : opb;
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opa} : 33'd0);
    div_shift = {acc_hi, acc_lo[31]};
    div_diff  = div_shift - {1'b0, opb};
    prod_mag  = {acc_hi, acc_lo};
    prod_fix  = qsign ? -prod_mag : prod_mag;
    quo_fix   = qsign ? -acc_lo : acc_lo;
    rem_fix   = rsign ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      qsign     <= 1'b0;
      rsign     <= 1'b0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      hi_r      <= '0;
      lo_r      <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                is_div    <= (bus.op == OP_DIV) || (bus.op == OP_DIVU);
                is_signed <= (bus.op == OP_MULT) || (bus.op == OP_DIV);
                opa       <= bus.rs_val;
                opb       <= bus.rt_val;
                state     <= S_PREP;
              end
              OP_MTHI: hi_r <= bus.rs_val;
              OP_MTLO: lo_r <= bus.rs_val;
              default: ;
            endcase
          end
        end
        S_PREP: begin
          opa    <= mag_a;
          opb    <= mag_b;
          qsign  <= use_sign && (opa[31] ^ opb[31]);
          rsign  <= use_sign && opa[31];
          acc_hi <= '0;
          acc_lo <= is_div ? mag_a : mag_b;
          cnt    <= '0;
          state  <= S_RUN;
        end
        S_RUN: begin
          if (is_div) begin
            // Restoring step: keep the trial difference only when it did not borrow.
            if (!div_diff[32]) begin
              acc_hi <= div_diff[31:0];
              acc_lo <= {acc_lo[30:0], 1'b1};
            end else begin
              acc_hi <= div_shift[31:0];
              acc_lo <= {acc_lo[30:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[32:1];
            acc_lo <= {mul_sum[0], acc_lo[31:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          if (is_div) begin
            lo_r <= quo_fix;
            hi_r <= rem_fix;
          end else begin
            hi_r <= prod_fix[63:32];
            lo_r <= prod_fix[31:0];
          end
          done_r <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign bus.busy  = (state != S_IDLE);
  assign bus.done  = done_r;
  assign bus.stall = bus.busy & (bus.rd_hilo | bus.start);
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb/tb_hilo_muldiv_ctrl.sv - randomized self-checking bench for hilo_muldiv_ctrl
module tb_hilo_muldiv_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_hi = 32'h0;
  logic [31:0] exp_lo = 32'h0;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl_if bus();
  hilo_muldiv_ctrl #(.ITER(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Reference result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_hilo(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    longint sp;
    int sq;
    int sr;
    r = 64'h0;
    case (o)
      3'b001: begin sp = longint'($signed(a)) * longint'($signed(b)); r = sp; end
      3'b010: r = {32'h0, a} * {32'h0, b};
      3'b011: begin
        if (b == 32'h0) r = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
        else begin sq = $signed(a) / $signed(b); sr = $signed(a) % $signed(b); r = {sr, sq}; end
      end
      3'b100: begin
        if (b == 32'h0) r = {a, 32'hFFFFFFFF};
        else r = {a % b, a / b};
      end
      default: r = 64'h0;
    endcase
    return r;
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int busy_cycles);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'($urandom); bus.rs_val = $urandom; bus.rt_val = $urandom;
    busy_cycles = 0;
    while (bus.busy === 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.op = 3'b000; bus.rs_val = '0; bus.rt_val = '0; bus.rd_hilo = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tests++; if (bus.hi !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
    tests++; if (bus.lo !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    bus.rd_hilo = 1'b1; #1;
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
    bus.rd_hilo = 1'b0;
    exp_hi = 32'h0; exp_lo = 32'h0;
  endtask

  task automatic test_mtx;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b101; bus.rs_val = 32'h12345678;
    @(negedge clk);
    tests++; if (bus.hi !== 32'h12345678) begin fails++; $display("FAIL mthi_hi: got %h expected 12345678", bus.hi); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL mthi_busy: got %b expected 0", bus.busy); end
    bus.op = 3'b110; bus.rs_val = 32'hCAFEF00D;
    @(negedge clk);
    tests++; if (bus.lo !== 32'hCAFEF00D) begin fails++; $display("FAIL mtlo_lo: got %h expected cafef00d", bus.lo); end
    tests++; if (bus.hi !== 32'h12345678) begin fails++; $display("FAIL mtlo_hi_kept: got %h expected 12345678", bus.hi); end
    bus.op = 3'b000; bus.rs_val = 32'h55555555;
    @(negedge clk);
    bus.op = 3'b111;
    @(negedge clk);
    bus.start = 1'b0;
    tests++; if (bus.hi !== 32'h12345678 || bus.lo !== 32'hCAFEF00D || bus.busy !== 1'b0) begin
      fails++; $display("FAIL nop_effect: got hi=%h lo=%h busy=%b expected 12345678 cafef00d 0", bus.hi, bus.lo, bus.busy);
    end
    exp_hi = 32'h12345678; exp_lo = 32'hCAFEF00D;
  endtask

  task automatic test_ops;
    logic [2:0]  dop [6] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b011, 3'b011};
    logic [31:0] da  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'hFFFFFF9C};
    logic [31:0] db  [6] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd0};
    logic [31:0] corner [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [2:0] o;
    logic [31:0] a, b;
    logic [63:0] e;
    int n;
    for (int i = 0; i < 30; i++) begin
      if (i < 6) begin
        o = dop[i]; a = da[i]; b = db[i];
      end else begin
        o = 3'($urandom_range(1, 4));
        a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
        b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
        if ($urandom_range(0, 5) == 0) b = -b;
      end
      e = ref_hilo(o, a, b);
      do_op(o, a, b, n);
      tests++; if (n !== 34) begin fails++; $display("FAIL op%0d_busy_len: got %0d expected 34", i, n); end
      tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL op%0d_done: got %b expected 1", i, bus.done); end
      tests++; if (bus.hi !== e[63:32]) begin fails++; $display("FAIL op%0d_hi op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, bus.hi, e[63:32]); end
      tests++; if (bus.lo !== e[31:0]) begin fails++; $display("FAIL op%0d_lo op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, bus.lo, e[31:0]); end
      @(negedge clk);
      tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL op%0d_done_pulse: got %b expected 0", i, bus.done); end
      exp_hi = e[63:32]; exp_lo = e[31:0];
    end
  endtask

  task automatic test_div_stall;
    logic [31:0] old_hi, old_lo;
    old_hi = exp_hi; old_lo = exp_lo;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b011; bus.rs_val = 32'hFFFFFFF9; bus.rt_val = 32'd2;
    @(negedge clk);
    bus.start = 1'b0; bus.rs_val = $urandom; bus.rt_val = $urandom;
    for (int k = 1; k <= 34; k++) begin
      if (k == 5 || k == 33) begin
        bus.rd_hilo = 1'b1; #1;
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL div_stall_c%0d: got %b expected 1", k, bus.stall); end
        tests++; if (bus.hi !== old_hi || bus.lo !== old_lo) begin
          fails++; $display("FAIL div_hold_c%0d: got hi=%h lo=%h expected %h %h", k, bus.hi, bus.lo, old_hi, old_lo);
        end
      end
      @(negedge clk);
      bus.rd_hilo = 1'b0;
    end
    bus.rd_hilo = 1'b1; #1;
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL div_done_stall: got %b expected 0", bus.stall); end
    tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL div_done: got %b expected 1", bus.done); end
    tests++; if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL div_result: got hi=%h lo=%h expected ffffffff fffffffd", bus.hi, bus.lo);
    end
    @(negedge clk);
    bus.rd_hilo = 1'b0;
    exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFFD;
  endtask

  task automatic test_mt_while_busy;
    logic [31:0] a, b;
    logic [63:0] e;
    a = $urandom; b = $urandom;
    e = ref_hilo(3'b001, a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b001; bus.rs_val = a; bus.rt_val = b;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      if (k == 10 || k == 20) begin
        bus.start = 1'b1; bus.op = (k == 10) ? 3'b110 : 3'b101; bus.rs_val = 32'hDEADBEEF; #1;
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL mt_busy_stall_c%0d: got %b expected 1", k, bus.stall); end
      end
      @(negedge clk);
      bus.start = 1'b0;
    end
    tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL mt_busy_done: got %b expected 1", bus.done); end
    tests++; if (bus.hi !== e[63:32] || bus.lo !== e[31:0]) begin
      fails++; $display("FAIL mt_busy_result: got hi=%h lo=%h expected %h %h", bus.hi, bus.lo, e[63:32], e[31:0]);
    end
    exp_hi = e[63:32]; exp_lo = e[31:0];
  endtask

  task automatic test_back_to_back;
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] e1, e2;
    int n;
    a1 = $urandom; b1 = 32'($urandom_range(1, 1000)); a2 = $urandom; b2 = $urandom;
    e1 = ref_hilo(3'b100, a1, b1);
    e2 = ref_hilo(3'b010, a2, b2);
    do_op(3'b100, a1, b1, n);
    tests++; if (bus.done !== 1'b1 || bus.lo !== e1[31:0] || bus.hi !== e1[63:32]) begin
      fails++; $display("FAIL b2b_first: got done=%b hi=%h lo=%h expected 1 %h %h", bus.done, bus.hi, bus.lo, e1[63:32], e1[31:0]);
    end
    bus.start = 1'b1; bus.op = 3'b010; bus.rs_val = a2; bus.rt_val = b2;
    @(negedge clk);
    bus.start = 1'b0;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_accept: got busy=%b expected 1", bus.busy); end
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    tests++; if (n !== 34) begin fails++; $display("FAIL b2b_busy_len: got %0d expected 34", n); end
    tests++; if (bus.hi !== e2[63:32] || bus.lo !== e2[31:0]) begin
      fails++; $display("FAIL b2b_second: got hi=%h lo=%h expected %h %h", bus.hi, bus.lo, e2[63:32], e2[31:0]);
    end
  endtask

  task automatic test_reset_mid_run;
    bit saw_update;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b010; bus.rs_val = 32'hFFFFFFFF; bus.rt_val = 32'hFFFFFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tests++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin fails++; $display("FAIL rst_mid_hilo: got %h %h expected 0 0", bus.hi, bus.lo); end
    tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL rst_mid_flags: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
    saw_update = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0) saw_update = 1'b1;
    end
    tests++; if (saw_update !== 1'b0) begin fails++; $display("FAIL rst_mid_late_update: got 1 expected 0"); end
  endtask

  initial begin
    test_reset;
    test_mtx;
    test_ops;
    test_div_stall;
    test_mt_while_busy;
    test_back_to_back;
    test_reset_mid_run;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end
endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Owns the HI and LO architectural registers that feed the operand-select mux.
- Sequences iterative multiply/divide, executes MTHI/MTLO, and raises a pipeline stall whenever HI/LO is read or a new mul/div is issued while an operation is in flight.
- Sits in EX beside the ALU. The hi/lo outputs connect directly to the HI/LO inputs of the operand-select mux.

Parameters:
- ITER, 32, number of shift/add or shift/subtract iterations. Must equal the operand width.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  issue strobe for op; sampled at rising edge.
- op  in  3  000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 NOP.
- rs_val  in  32  multiplicand / dividend / MTHI-MTLO source.
- rt_val  in  32  multiplier / divisor.
- rd_hilo  in  1  decode has MFHI/MFLO (or a HI/LO operand select) in EX this cycle.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  mul/div in flight.
- done  out  1  one-cycle pulse after HI/LO are written by mul/div.
- stall  out  1  combinational: busy & (rd_hilo | start).

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, FSM=IDLE, iteration counter=0, internal accumulators=0. Reset applied mid-operation aborts it with no HI/LO update.
- States: IDLE, PREP, RUN, FIX.
- IDLE, start & op in {MULT, MULTU, DIV, DIVU}:
  - Latch op, rs_val, rt_val.
  - Go to PREP; busy=1 from the next cycle.
- IDLE, start & MTHI/MTLO:
  - hi (or lo) <= rs_val at that edge.
  - Stay in IDLE; busy stays 0.
- IDLE, start & NOP: no effect.
- PREP (1 cycle):
  - Signed ops: take magnitudes of both operands (0x80000000 magnitude = 0x80000000 unsigned) and record result signs.
  - qsign = rs[31]^rt[31]; rsign = rs[31].
  - Unsigned ops: operands pass through unchanged.
  - Counter <= 0; go to RUN.
- RUN (exactly ITER cycles):
  - Multiply: one shift-add step per cycle on a 64-bit product.
  - Divide: one restoring shift/subtract step per cycle (33-bit partial remainder).
  - Counter increments each cycle; when counter == ITER-1, go to FIX.
- FIX (1 cycle):
  - Apply sign correction. Product negated if qsign; quotient negated if qsign; remainder negated if rsign.
  - At the FIX edge: multiply writes hi=product[63:32], lo=product[31:0]; divide writes lo=quotient, hi=remainder.
  - Go to IDLE; busy falls and done=1 for the following cycle.
- Latency: start sampled at edge E0 → HI/LO updated at edge E0+ITER+2 (34). busy is high for exactly 34 cycles.
- Divide by zero: still takes 34 cycles; result lo=0xFFFFFFFF, hi=rs_val (unsigned magnitude path, no sign fix).
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Division truncates toward zero; remainder takes the dividend's sign.
- start while busy: ignored (not queued). stall=1 that cycle; the issuing stage must hold and re-present start.
- rd_hilo while busy: stall=1. hi/lo keep their old values until the FIX edge.
- rd_hilo in the cycle done=1: stall=0, new values visible.
- start & MTHI/MTLO while busy: ignored and stall=1. HI/LO are never written outside the FIX edge while busy.
- start in the done cycle: accepted normally (FSM is IDLE).
- op latched in IDLE only; changes on op/rs_val/rt_val during busy have no effect.

Test Plan:
- Reset held 2 cycles mid-RUN of MULTU → hi=lo=0, busy=0, done=0, no later update.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → after 34 cycles hi=0xFFFFFFFE, lo=0x00000001, done pulse 1 cycle, busy high exactly 34 cycles.
- MULT −3×7 (0xFFFFFFFD, 7) → hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/0 → lo=0xFFFFFFFF, hi=100. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- During a DIV, assert rd_hilo at cycles 5 and 33 → stall=1 both cycles with hi/lo unchanged. rd_hilo in the done cycle → stall=0 with the quotient on lo.
- MTHI 0x12345678 then MTLO 0xCAFEF00D on consecutive cycles while idle → values appear after each edge, busy=0. MTLO issued mid-MULT → ignored, stall=1, lo ends as the product low word.
